elevator_request_scheduler: RTL and testbench

ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

---
 rtl/elevator_pkg.sv | 26 ++
 rtl/elevator_nearest_call.sv | 34 +++
 rtl/elevator_request_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants, direction codes and scheduler state encodings for the
// elevator request scheduler and its helpers.
package elevator_pkg;

  localparam int unsigned FLOOR_W   = 4;
  localparam int unsigned MIN_FLOOR = 0;
  localparam int unsigned MAX_FLOOR = 15;
  localparam int unsigned NUM_SLOTS = MAX_FLOOR + 1;

  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b01;
  localparam logic [1:0] DIR_NONE = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_UP   = 3'd1,
    ST_SERVE_DOWN = 3'd2,
    ST_DOOR       = 3'd3,
    ST_HALT       = 3'd4
  } sched_state_t;

  function automatic logic [NUM_SLOTS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    return NUM_SLOTS'(1) << f;
  endfunction

endpackage

// File: rtl/elevator_nearest_call.sv
// Combinational search of the pending-call vector for the closest call
// strictly above and strictly below the car.
module elevator_nearest_call
  import elevator_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] i_pending,
  input  logic [FLOOR_W-1:0]   i_current_floor,
  output logic                 o_any_above,
  output logic [FLOOR_W-1:0]   o_nearest_above,
  output logic                 o_any_below,
  output logic [FLOOR_W-1:0]   o_nearest_below
);

  // Scan top-down for above (last hit = lowest) and bottom-up for below (last hit = highest).
  always_comb begin
    o_any_above     = 1'b0;
    o_nearest_above = '0;
    o_any_below     = 1'b0;
    o_nearest_below = '0;
    for (int i = int'(MAX_FLOOR); i >= int'(MIN_FLOOR); i--) begin
      if (i_pending[FLOOR_W'(i)] && (i > int'(i_current_floor))) begin
        o_any_above     = 1'b1;
        o_nearest_above = FLOOR_W'(i);
      end
    end
    for (int i = int'(MIN_FLOOR); i <= int'(MAX_FLOOR); i++) begin
      if (i_pending[FLOOR_W'(i)] && (i < int'(i_current_floor))) begin
        o_any_below     = 1'b1;
        o_nearest_below = FLOOR_W'(i);
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Latches floor calls and steers the car up/down, dwelling with the door
// open at each served floor; emergency forces a halt with doors open.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = 16,
  parameter int unsigned DOOR_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 call_valid,
  input  logic [FLOOR_W-1:0]   call_floor,
  input  logic                 emergency,
  input  logic [FLOOR_W-1:0]   current_floor,
  input  logic                 arrived,
  output logic [FLOOR_W-1:0]   target_floor,
  output logic                 target_valid,
  output logic [1:0]           dir_pref,
  output logic                 door_open,
  output logic [NUM_SLOTS-1:0] pending,
  output logic                 busy
);

  localparam int unsigned DWELL_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DOOR_CYCLES - 1);

  sched_state_t           r_state;
  logic [NUM_SLOTS-1:0]   r_pending;
  logic [FLOOR_W-1:0]     r_target_floor;
  logic                   r_target_valid;
  logic [1:0]             r_dir;
  logic                   r_door_open;
  logic                   r_busy;
  logic [DWELL_W-1:0]     r_dwell;

  logic                   w_any_above;
  logic [FLOOR_W-1:0]     w_nearest_above;
  logic                   w_any_below;
  logic [FLOOR_W-1:0]     w_nearest_below;
  logic                   w_call_ok;
  logic                   w_door_call;
  logic                   w_here;
  logic                   w_serving;
  logic                   w_clear;
  logic [NUM_SLOTS-1:0]   w_set_mask;
  logic [NUM_SLOTS-1:0]   w_clr_mask;
  logic [NUM_SLOTS-1:0]   w_pending_nxt;

  elevator_nearest_call u_nearest (
    .i_pending       (r_pending),
    .i_current_floor (current_floor),
    .o_any_above     (w_any_above),
    .o_nearest_above (w_nearest_above),
    .o_any_below     (w_any_below),
    .o_nearest_below (w_nearest_below)
  );

  // A call for the floor the door is open at only extends the dwell; clear beats set.
  assign w_call_ok     = call_valid && (32'(call_floor) < NUM_FLOORS);
  assign w_door_call   = w_call_ok && (r_state == ST_DOOR) && (call_floor == current_floor);
  assign w_here        = r_pending[current_floor];
  assign w_serving     = (r_state == ST_SERVE_UP) || (r_state == ST_SERVE_DOWN);
  assign w_clear       = !emergency && w_here && ((r_state == ST_IDLE) || (w_serving && arrived));
  assign w_set_mask    = (w_call_ok && (r_state != ST_HALT) && !w_door_call)
                         ? floor_onehot(call_floor) : '0;
  assign w_clr_mask    = w_clear ? floor_onehot(current_floor) : '0;
  assign w_pending_nxt = (r_pending | w_set_mask) & ~w_clr_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_pending      <= '0;
      r_target_floor <= '0;
      r_target_valid <= 1'b0;
      r_dir          <= DIR_NONE;
      r_door_open    <= 1'b0;
      r_busy         <= 1'b0;
      r_dwell        <= '0;
    end else begin
      r_pending      <= w_pending_nxt;
      r_target_valid <= 1'b0;
      r_door_open    <= 1'b0;
      r_busy         <= 1'b1;
      if (emergency) begin
        r_state     <= ST_HALT;
        r_door_open <= 1'b1;
        r_dir       <= DIR_NONE;
        r_dwell     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_here) begin
              r_state     <= ST_DOOR;
              r_door_open <= 1'b1;
              r_dwell     <= DWELL_LOAD;
            end else if (w_any_above) begin
              r_state        <= ST_SERVE_UP;
              r_target_floor <= w_nearest_above;
              r_target_valid <= 1'b1;
              r_dir          <= DIR_UP;
            end else if (w_any_below) begin
              r_state        <= ST_SERVE_DOWN;
              r_target_floor <= w_nearest_below;
              r_target_valid <= 1'b1;
              r_dir          <= DIR_DOWN;
            end else begin
              r_busy <= 1'b0;
              r_dir  <= DIR_NONE;
            end
          end

          ST_SERVE_UP, ST_SERVE_DOWN: begin
            if (arrived && w_here) begin
              r_state     <= ST_DOOR;
              r_door_open <= 1'b1;
              r_dwell     <= DWELL_LOAD;
            end else if ((r_state == ST_SERVE_UP) && w_any_above) begin
              r_target_floor <= w_nearest_above;
              r_target_valid <= 1'b1;
            end else if ((r_state == ST_SERVE_DOWN) && w_any_below) begin
              r_target_floor <= w_nearest_below;
              r_target_valid <= 1'b1;
            end else begin
              // Nothing left in this direction: re-evaluate from idle next cycle.
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_dir   <= DIR_NONE;
            end
          end

          ST_DOOR: begin
            r_door_open <= 1'b1;
            if (w_door_call) begin
              r_dwell <= DWELL_LOAD;
            end else if (r_dwell != '0) begin
              r_dwell <= r_dwell - 1'b1;
            end else begin
              r_door_open <= 1'b0;
              if ((r_dir == DIR_UP) && w_any_above) begin
                r_state        <= ST_SERVE_UP;
                r_target_floor <= w_nearest_above;
                r_target_valid <= 1'b1;
              end else if ((r_dir == DIR_DOWN) && w_any_below) begin
                r_state        <= ST_SERVE_DOWN;
                r_target_floor <= w_nearest_below;
                r_target_valid <= 1'b1;
              end else if ((r_dir == DIR_UP) && w_any_below) begin
                r_state        <= ST_SERVE_DOWN;
                r_target_floor <= w_nearest_below;
                r_target_valid <= 1'b1;
                r_dir          <= DIR_DOWN;
              end else if ((r_dir == DIR_DOWN) && w_any_above) begin
                r_state        <= ST_SERVE_UP;
                r_target_floor <= w_nearest_above;
                r_target_valid <= 1'b1;
                r_dir          <= DIR_UP;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_dir   <= DIR_NONE;
              end
            end
          end

          ST_HALT: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_dir   <= DIR_NONE;
            r_dwell <= '0;
          end

          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_dir   <= DIR_NONE;
          end
        endcase
      end
    end
  end

  assign target_floor = r_target_floor;
  assign target_valid = r_target_valid;
  assign dir_pref     = r_dir;
  assign door_open    = r_door_open;
  assign pending      = r_pending;
  assign busy         = r_busy;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_elevator_request_scheduler;

  localparam int unsigned NF = 12;
  localparam int unsigned DC = 8;
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3, M_HALT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        call_valid;
  logic [3:0]  call_floor;
  logic        emergency;
  logic [3:0]  current_floor;
  logic        arrived;
  logic [3:0]  target_floor;
  logic        target_valid;
  logic [1:0]  dir_pref;
  logic        door_open;
  logic [15:0] pending;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  // Model: mode, travel direction (+1/-1/0), target, door cycles remaining, calls.
  int        m_mode;
  int        m_dir;
  int        m_target;
  int        m_left;
  bit [15:0] m_pend;

  elevator_request_scheduler #(.NUM_FLOORS(NF), .DOOR_CYCLES(DC)) dut (
    .clk           (clk),
    .reset         (reset),
    .call_valid    (call_valid),
    .call_floor    (call_floor),
    .emergency     (emergency),
    .current_floor (current_floor),
    .arrived       (arrived),
    .target_floor  (target_floor),
    .target_valid  (target_valid),
    .dir_pref      (dir_pref),
    .door_open     (door_open),
    .pending       (pending),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic int lowest_above(input bit [15:0] p, input int f);
    for (int i = f + 1; i < 16; i++) if (p[4'(i)]) return i;
    return -1;
  endfunction

  function automatic int highest_below(input bit [15:0] p, input int f);
    for (int i = f - 1; i >= 0; i--) if (p[4'(i)]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_dir = 0; m_target = 0; m_left = 0; m_pend = '0;
  endtask

  task automatic model_step(input bit cv, input int cfl, input bit em, input int cur, input bit arr);
    int  up, dn;
    bit  here, legal, restart, take, clr;
    up      = lowest_above(m_pend, cur);
    dn      = highest_below(m_pend, cur);
    here    = m_pend[4'(cur)];
    legal   = cv && (cfl < int'(NF));
    restart = legal && (m_mode == M_DOOR) && (cfl == cur);
    take    = legal && (m_mode != M_HALT) && !restart;
    clr     = 1'b0;
    if (em) begin
      m_mode = M_HALT; m_dir = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (here) begin clr = 1'b1; m_mode = M_DOOR; m_left = int'(DC); end
          else if (up >= 0) begin m_mode = M_UP; m_dir = 1; m_target = up; end
          else if (dn >= 0) begin m_mode = M_DOWN; m_dir = -1; m_target = dn; end
          else m_dir = 0;
        end
        M_UP, M_DOWN: begin
          if (arr && here) begin clr = 1'b1; m_mode = M_DOOR; m_left = int'(DC); end
          else if (m_mode == M_UP && up >= 0) m_target = up;
          else if (m_mode == M_DOWN && dn >= 0) m_target = dn;
          else begin m_mode = M_IDLE; m_dir = 0; end
        end
        M_DOOR: begin
          if (restart) m_left = int'(DC);
          else if (m_left > 1) m_left--;
          else if (m_dir == 1 && up >= 0) begin m_mode = M_UP; m_target = up; end
          else if (m_dir == -1 && dn >= 0) begin m_mode = M_DOWN; m_target = dn; end
          else if (m_dir == 1 && dn >= 0) begin m_mode = M_DOWN; m_dir = -1; m_target = dn; end
          else if (m_dir == -1 && up >= 0) begin m_mode = M_UP; m_dir = 1; m_target = up; end
          else begin m_mode = M_IDLE; m_dir = 0; end
        end
        default: begin m_mode = M_IDLE; m_dir = 0; end
      endcase
    end
    if (take) m_pend[4'(cfl)] = 1'b1;
    if (clr)  m_pend[4'(cur)] = 1'b0;
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic compare_model();
    bit       e_tv, e_door, e_busy, ok;
    bit [1:0] e_dir;
    e_tv   = (m_mode == M_UP) || (m_mode == M_DOWN);
    e_door = (m_mode == M_DOOR) || (m_mode == M_HALT);
    e_busy = (m_mode != M_IDLE);
    e_dir  = (m_dir > 0) ? 2'b10 : (m_dir < 0) ? 2'b01 : 2'b00;
    ok = (pending === m_pend) && (target_valid === e_tv) && (door_open === e_door) &&
         (busy === e_busy) && (dir_pref === e_dir) &&
         (!e_tv || (target_floor === 4'(m_target)));
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL model @%0t: pend %h/%h tv %b/%b tgt %0d/%0d dir %b/%b door %b/%b busy %b/%b",
                  $time, pending, m_pend, target_valid, e_tv, target_floor, m_target,
                  dir_pref, e_dir, door_open, e_door, busy, e_busy);
  endtask

  // One clock: drive inputs, advance model at the edge, compare on the falling edge.
  task automatic cycle(input bit cv, input int cfl, input bit em, input int cur, input bit arr);
    call_valid = cv; call_floor = 4'(cfl); emergency = em;
    current_floor = 4'(cur); arrived = arr;
    @(posedge clk);
    if (!reset) model_step(cv, cfl, em, cur, arr);
    @(negedge clk);
    compare_model();
  endtask

  task automatic drain_door(input int cur, output int n);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      if (!door_open) break;
      n++;
      cycle(1'b0, 0, 1'b0, cur, 1'b0);
    end
    expect_eq("door_closes", 32'(door_open), 32'd0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 compare_model();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n, cur, em_left;
    reset = 1'b1; call_valid = 1'b0; call_floor = '0; emergency = 1'b0;
    current_floor = '0; arrived = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    expect_eq("rst_pending", 32'(pending), 32'd0);
    expect_eq("rst_busy", 32'(busy), 32'd0);
    expect_eq("rst_door", 32'(door_open), 32'd0);
    expect_eq("rst_tv", 32'(target_valid), 32'd0);
    expect_eq("rst_dir", 32'(dir_pref), 32'd0);
    reset = 1'b0;

    // Single call above, serve, dwell, back to idle.
    cycle(1'b1, 5, 1'b0, 0, 1'b0);
    expect_eq("call5_latched", 32'(pending), 32'h0020);
    cycle(1'b0, 0, 1'b0, 0, 1'b0);
    expect_eq("up_target", 32'(target_floor), 32'd5);
    expect_eq("up_dir", 32'(dir_pref), 32'h2);
    expect_eq("up_tv", 32'(target_valid), 32'd1);
    for (int f = 1; f < 5; f++) cycle(1'b0, 0, 1'b0, f, 1'b0);
    cycle(1'b0, 0, 1'b0, 5, 1'b1);
    expect_eq("arrive5_pending", 32'(pending), 32'd0);
    expect_eq("arrive5_door", 32'(door_open), 32'd1);
    drain_door(5, n);
    expect_eq("dwell_len", 32'(n), 32'd8);
    expect_eq("idle_busy", 32'(busy), 32'd0);
    expect_eq("idle_dir", 32'(dir_pref), 32'd0);

    // En-route pickup.
    cycle(1'b0, 0, 1'b0, 2, 1'b0);
    cycle(1'b1, 9, 1'b0, 2, 1'b0);
    cycle(1'b0, 0, 1'b0, 2, 1'b0);
    expect_eq("to9_target", 32'(target_floor), 32'd9);
    cycle(1'b1, 6, 1'b0, 2, 1'b0);
    cycle(1'b0, 0, 1'b0, 3, 1'b0);
    expect_eq("enroute_target", 32'(target_floor), 32'd6);
    cycle(1'b0, 0, 1'b0, 4, 1'b0);
    cycle(1'b0, 0, 1'b0, 5, 1'b0);
    cycle(1'b0, 0, 1'b0, 6, 1'b1);
    drain_door(6, n);
    expect_eq("resume_target", 32'(target_floor), 32'd9);
    expect_eq("resume_tv", 32'(target_valid), 32'd1);
    cycle(1'b0, 0, 1'b0, 7, 1'b0);
    cycle(1'b0, 0, 1'b0, 8, 1'b0);
    cycle(1'b0, 0, 1'b0, 9, 1'b1);
    drain_door(9, n);

    // Continue upward first, then reverse.
    cycle(1'b1, 8, 1'b0, 5, 1'b0);
    cycle(1'b1, 12 - 1, 1'b0, 5, 1'b0);
    cycle(1'b1, 3, 1'b0, 6, 1'b0);
    cycle(1'b0, 0, 1'b0, 7, 1'b0);
    cycle(1'b0, 0, 1'b0, 8, 1'b1);
    expect_eq("at8_pending", 32'(pending), 32'h0808);
    drain_door(8, n);
    expect_eq("continue_up_target", 32'(target_floor), 32'd11);
    expect_eq("continue_up_dir", 32'(dir_pref), 32'h2);
    cycle(1'b0, 0, 1'b0, 9, 1'b0);
    cycle(1'b0, 0, 1'b0, 10, 1'b0);
    cycle(1'b0, 0, 1'b0, 11, 1'b1);
    drain_door(11, n);
    expect_eq("reverse_target", 32'(target_floor), 32'd3);
    expect_eq("reverse_dir", 32'(dir_pref), 32'h1);

    // Emergency while serving down.
    cycle(1'b1, 1, 1'b0, 10, 1'b0);
    cycle(1'b0, 0, 1'b0, 10, 1'b0);
    expect_eq("down_pending", 32'(pending), 32'h000A);
    cycle(1'b0, 0, 1'b1, 9, 1'b0);
    expect_eq("halt_door", 32'(door_open), 32'd1);
    expect_eq("halt_tv", 32'(target_valid), 32'd0);
    expect_eq("halt_dir", 32'(dir_pref), 32'd0);
    expect_eq("halt_pending", 32'(pending), 32'h000A);
    cycle(1'b1, 5, 1'b1, 9, 1'b0);
    expect_eq("halt_call_ignored", 32'(pending), 32'h000A);
    cycle(1'b0, 0, 1'b0, 9, 1'b0);
    expect_eq("halt_release_busy", 32'(busy), 32'd0);
    cycle(1'b0, 0, 1'b0, 9, 1'b0);
    expect_eq("after_halt_target", 32'(target_floor), 32'd3);
    expect_eq("after_halt_dir", 32'(dir_pref), 32'h1);
    cycle(1'b0, 0, 1'b0, 3, 1'b1);
    drain_door(3, n);
    cycle(1'b0, 0, 1'b0, 1, 1'b1);
    drain_door(1, n);

    // Call for the floor the door is open at restarts the dwell.
    cycle(1'b1, 4, 1'b0, 4, 1'b0);
    cycle(1'b0, 0, 1'b0, 4, 1'b0);
    expect_eq("door4_open", 32'(door_open), 32'd1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 0, 1'b0, 4, 1'b0);
    cycle(1'b1, 4, 1'b0, 4, 1'b0);
    expect_eq("door4_no_pending", 32'(pending), 32'd0);
    drain_door(4, n);
    expect_eq("restart_dwell", 32'(n), 32'd8);

    // Asynchronous reset in the middle of a dwell with calls outstanding.
    cycle(1'b1, 4, 1'b0, 4, 1'b0);
    cycle(1'b1, 7, 1'b0, 4, 1'b0);
    cycle(1'b1, 10, 1'b0, 4, 1'b0);
    expect_eq("pre_reset_pending", 32'(pending), 32'h0480);
    expect_eq("pre_reset_door", 32'(door_open), 32'd1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    expect_eq("async_rst_pending", 32'(pending), 32'd0);
    expect_eq("async_rst_door", 32'(door_open), 32'd0);
    expect_eq("async_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 15, 1'b0, 0, 1'b0);
    expect_eq("call15_ignored", 32'(pending), 32'd0);
    cycle(1'b1, 12, 1'b0, 0, 1'b0);
    expect_eq("call12_ignored", 32'(pending), 32'd0);
    cycle(1'b1, 11, 1'b0, 0, 1'b0);
    expect_eq("call11_taken", 32'(pending), 32'h0800);

    // Randomized traffic with a car that follows the model's target.
    cur = 0;
    em_left = 0;
    for (int c = 0; c < 4000; c++) begin
      bit cv, em, arr;
      int cfl;
      if (($urandom % 700) == 0) pulse_reset();
      if (em_left > 0) begin
        em = 1'b1; em_left--;
      end else begin
        em = 1'b0;
        if (($urandom % 150) == 0) em_left = int'($urandom_range(1, 4));
      end
      cv  = (($urandom % 3) == 0);
      cfl = (($urandom % 4) == 0) ? cur : int'($urandom_range(0, 15));
      arr = 1'b0;
      if ((m_mode == M_UP) || (m_mode == M_DOWN)) begin
        if (cur == m_target) arr = 1'($urandom % 2);
        else if (($urandom % 2) == 0) cur += (m_target > cur) ? 1 : -1;
      end
      if (($urandom % 20) == 0) arr = 1'b1;
      if (($urandom % 60) == 0) cur = int'($urandom_range(0, 15));
      cycle(cv, cfl, em, cur, arr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
